// File: rtl/spi_reg_bank_pkg.sv
// Shared constants for the SPI register bank: FSM encoding, command-byte
// layout and the address-counter width.
package spi_pkg;

    // FSM state encoding, kept as plain constants for legacy compatibility
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_CMD        = 3'd1;
    localparam state_t ST_WRITE      = 3'd2;
    localparam state_t ST_READ       = 3'd3;
    localparam state_t ST_WAIT_DESEL = 3'd4;

    // Command byte: bit 7 selects write (1) or read (0), bits 6:0 the start address
    localparam int CMD_BIT   = 7;
    localparam int ADDR_BITS = 7;

    typedef logic [ADDR_BITS-1:0] addr_t;

    // True when the 7-bit frame address maps onto a physical register
    // of a bank indexed by aw bits.
    function automatic logic addr_in_range(input addr_t a, input int unsigned aw);
        if (aw >= ADDR_BITS) begin
            return 1'b1;
        end
        return ((a >> aw) == '0);
    endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Byte-level link between an SPI slave shifter and the register bank.
// The shifter side drives select and byte strobes; the bank returns txdata.
interface spi_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic             ss;
    logic [WIDTH-1:0] rxdata;
    logic             rxready;
    logic             txready;
    logic [WIDTH-1:0] txdata;

    // SPI shifter side
    modport master (
        output ss,
        output rxdata,
        output rxready,
        output txready,
        input  txdata
    );

    // Register bank side
    modport slave (
        input  ss,
        input  rxdata,
        input  rxready,
        input  txready,
        output txdata
    );

endinterface

// File: rtl/spi_reg_bank_sync2.sv
// Two-flop synchroniser for a single asynchronous level. No reset so it can
// be dropped into any clock domain, including pulse-crossing blocks.
module sync2 (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw level through two flops to settle metastability
    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-addressed register bank. Each frame starts with a command byte
// {rw, addr[6:0]}; the remaining bytes write consecutive registers (rw=1)
// or stream consecutive registers back on MISO (rw=0). The first MISO byte
// of every frame is the status input. The SPI shifter lives in the parent.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ADDRW = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    spi_reg_bank_if.slave                  bus,
    input  logic [WIDTH-1:0]               status,
    output logic [(2**ADDRW)*WIDTH-1:0]    regs,
    output logic                           wr_strobe,
    output logic [ADDRW-1:0]               wr_addr
);

    localparam int unsigned NREGS = 2**ADDRW;

    logic             ss_sync;
    logic             selected;
    logic             sel_prev;
    logic             sel_rise;
    state_t           state;
    addr_t            addr;
    logic [ADDRW-1:0] idx;
    logic             addr_ok;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] mem [NREGS];

    sync2 u_ss_sync (
        .clk (clk),
        .d   (bus.ss),
        .q   (ss_sync)
    );

    // Slave-select is active-low; work with a positive "selected" level
    always_comb begin
        selected = ~ss_sync;
        sel_rise = selected & ~sel_prev;
    end

    // Decode the frame address into a register index and its read value;
    // addresses beyond the bank read back as zero
    always_comb begin
        idx     = ADDRW'(addr);
        addr_ok = addr_in_range(addr, ADDRW);
        rd_data = addr_ok ? mem[idx] : '0;
    end

    // Previous selected level for start-of-frame edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_prev <= 1'b0;
        end else begin
            sel_prev <= selected;
        end
    end

    // Frame FSM, address counter, register array and MISO byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WAIT_DESEL;
            addr       <= '0;
            bus.txdata <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                ST_WAIT_DESEL: begin
                    // A frame already running at reset release is skipped whole
                    if (!selected) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (sel_rise) begin
                        state      <= ST_CMD;
                        bus.txdata <= status;
                    end
                end

                ST_CMD: begin
                    // Deselection is checked first so a coincident byte is dropped
                    if (!selected) begin
                        state <= ST_IDLE;
                    end else if (bus.rxready) begin
                        addr <= bus.rxdata[ADDR_BITS-1:0];
                        if (bus.rxdata[CMD_BIT]) begin
                            state      <= ST_WRITE;
                            bus.txdata <= '0;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end

                ST_WRITE: begin
                    bus.txdata <= '0;
                    if (!selected) begin
                        state <= ST_IDLE;
                    end else if (bus.rxready) begin
                        if (addr_ok) begin
                            mem[idx]  <= bus.rxdata;
                            wr_strobe <= 1'b1;
                            wr_addr   <= idx;
                        end
                        addr <= addr + 1'b1;
                    end
                end

                ST_READ: begin
                    // txdata tracks the current address every cycle, so it
                    // lands one cycle after each increment; rxready is ignored
                    if (!selected) begin
                        state <= ST_IDLE;
                    end else begin
                        bus.txdata <= rd_data;
                        if (bus.txready) begin
                            addr <= addr + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_WAIT_DESEL;
                end
            endcase
        end
    end

    // Flatten the array onto the register image port
    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i*WIDTH +: WIDTH] = mem[i];
        end
    end

endmodule
